bram_access_controller: RTL

- BRAM-side controller for the matrix multiplication accelerator. It sits directly beside the accelerator FSM.
- It services the FSM's fetch_A, fetch_B and store_C requests against three single-port BRAMs: A rows, B rows, C rows.
- It returns fetch_A_ready, fetch_B_ready and store_C_ready pulses to the FSM, together with the captured A/B row data.
- It keeps the row counter and drives the full flag that ends the FSM's Write_row_C -> IDLE path.

---
 rtl/bram_access_controller.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/bram_access_controller.sv
// BRAM-side controller for the matrix multiply accelerator.
// It services the fetch_A, fetch_B and store_C requests from the accelerator
// FSM against three single-port BRAMs. It returns one-cycle ready pulses and
// keeps the row and k counters plus the sticky full and req_err flags.
//
// state | meaning
// IDLE  | waiting for a request; the only state that accepts one
// RD_A  | A read issued, counting down the BRAM read latency
// RD_B  | B read issued, counting down the BRAM read latency
// WR_C  | C write enable asserted for its single cycle
module bram_access_controller #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int ADDR_W = 4,
  parameter int RD_LAT = 1,
  localparam int IW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                fetch_A,
  input  logic                fetch_B,
  input  logic                store_C,
  input  logic [N*ACC_W-1:0]  c_row,
  output logic                fetch_A_ready,
  output logic                fetch_B_ready,
  output logic                store_C_ready,
  output logic                full,
  output logic                req_err,
  output logic [N*DATA_W-1:0] a_row,
  output logic [N*DATA_W-1:0] b_row,
  output logic [IW-1:0]       b_index,
  output logic                bram_a_en,
  output logic [ADDR_W-1:0]   bram_a_addr,
  input  logic [N*DATA_W-1:0] bram_a_dout,
  output logic                bram_b_en,
  output logic [ADDR_W-1:0]   bram_b_addr,
  input  logic [N*DATA_W-1:0] bram_b_dout,
  output logic                bram_c_we,
  output logic [ADDR_W-1:0]   bram_c_addr,
  output logic [N*ACC_W-1:0]  bram_c_din
);

  // RD_LAT is limited to 1..3, so two bits cover the wait counter
  localparam int CW = 2;

  typedef enum logic [1:0] {IDLE, RD_A, RD_B, WR_C} state_t;

  state_t        state;
  logic [IW-1:0] row_i;
  logic [IW-1:0] k;
  logic [CW-1:0] wait_cnt;

  // A request in the same cycle as start sees the cleared counters and flag
  logic          full_eff;
  logic [IW-1:0] row_cur;
  logic [IW-1:0] k_cur;
  logic          drop;

  assign full_eff = full & ~start;
  assign row_cur  = start ? '0 : row_i;
  assign k_cur    = start ? '0 : k;

  // Flag any request that loses arbitration, arrives while busy, or is a fetch while full
  always_comb begin
    drop = 1'b0;
    if (state != IDLE)  drop = store_C | fetch_A | fetch_B;
    else if (store_C)   drop = fetch_A | fetch_B;
    else if (fetch_A)   drop = full_eff | fetch_B;
    else if (fetch_B)   drop = full_eff;
  end

  // Main FSM: request acceptance, read-latency countdown, capture and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      row_i         <= '0;
      k             <= '0;
      wait_cnt      <= '0;
      fetch_A_ready <= 1'b0;
      fetch_B_ready <= 1'b0;
      store_C_ready <= 1'b0;
      full          <= 1'b0;
      req_err       <= 1'b0;
      a_row         <= '0;
      b_row         <= '0;
      b_index       <= '0;
      bram_a_en     <= 1'b0;
      bram_a_addr   <= '0;
      bram_b_en     <= 1'b0;
      bram_b_addr   <= '0;
      bram_c_we     <= 1'b0;
      bram_c_addr   <= '0;
      bram_c_din    <= '0;
    end else begin
      fetch_A_ready <= 1'b0;
      fetch_B_ready <= 1'b0;
      store_C_ready <= 1'b0;
      bram_a_en     <= 1'b0;
      bram_b_en     <= 1'b0;
      bram_c_we     <= 1'b0;
      req_err       <= (req_err & ~start) | drop;

      case (state)
        IDLE: begin
          if (store_C) begin
            state       <= WR_C;
            bram_c_we   <= 1'b1;
            bram_c_addr <= ADDR_W'(row_cur);
            bram_c_din  <= c_row;
          end else if (fetch_A && !full_eff) begin
            state       <= RD_A;
            bram_a_en   <= 1'b1;
            bram_a_addr <= ADDR_W'(row_cur);
            wait_cnt    <= CW'(RD_LAT);
            k           <= '0;
          end else if (fetch_B && !full_eff) begin
            state       <= RD_B;
            bram_b_en   <= 1'b1;
            bram_b_addr <= ADDR_W'(k_cur);
            wait_cnt    <= CW'(RD_LAT);
          end
        end

        RD_A: begin
          if (wait_cnt == '0) begin
            a_row         <= bram_a_dout;
            fetch_A_ready <= 1'b1;
            state         <= IDLE;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end

        RD_B: begin
          if (wait_cnt == '0) begin
            b_row         <= bram_b_dout;
            b_index       <= k;
            fetch_B_ready <= 1'b1;
            k             <= (k == IW'(N - 1)) ? '0 : k + IW'(1);
            state         <= IDLE;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end

        WR_C: begin
          store_C_ready <= 1'b1;
          state         <= IDLE;
          if (row_i == IW'(N - 1)) begin
            row_i <= '0;
            full  <= 1'b1;
          end else begin
            row_i <= row_i + IW'(1);
          end
        end

        default: state <= IDLE;
      endcase

      // start wins over any counter update from a transaction finishing on this edge
      if (start) begin
        row_i <= '0;
        k     <= '0;
        full  <= 1'b0;
      end
    end
  end

endmodule
